// File: rtl/pc_seq_pkg.sv
// pc_sequencer shared types and constants.
// State encoding, XLEN, default vectors and instruction stride.
package pc_seq_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  localparam logic [XLEN-1:0] INSTR_STRIDE = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK   = INSTR_STRIDE - 32'd1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } state_t;

  function automatic logic is_misaligned(
    input logic [XLEN-1:0] addr
  );
    return |(addr & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: PC+4, branch target or trap vector.
// Trap redirect exists only with PC_MISALIGN_TRAP_EN.
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PC_Target,
  input  logic            Branch_Taken,
`ifdef PC_MISALIGN_TRAP_EN
  input  logic [XLEN-1:0] Trap_Vector,
  output logic            Misaligned,
`endif
  output logic [XLEN-1:0] Next_PC
);

  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = PC + INSTR_STRIDE;

`ifdef PC_MISALIGN_TRAP_EN
  assign Misaligned = Branch_Taken
                    & is_misaligned(PC_Target);

  // trap wins over a taken branch with a bad target
  always_comb begin
    Next_PC = pc_plus4;
    unique case (1'b1)
      Misaligned:
        Next_PC = Trap_Vector;
      Branch_Taken && !Misaligned:
        Next_PC = PC_Target;
      default: ;
    endcase
  end
`else
  // low target bits are dropped so PC stays word aligned
  always_comb begin
    Next_PC = pc_plus4;
    unique case (1'b1)
      Branch_Taken:
        Next_PC = PC_Target & ~ALIGN_MASK;
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-path PC sequencer: BOOT -> REQ -> EXEC loop.
// Optional misaligned-target trap via PC_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR =
    DEF_RESET_VECTOR
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VECTOR =
    DEF_TRAP_VECTOR
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_Target,
  input  logic            Branch_Taken,
  input  logic            Stall,
  input  logic            Fetch_Ack,
  output logic            Fetch_Req,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Plus4,
  output logic            Instr_Valid,
  output logic [XLEN-1:0] Instr_Count,
  output logic            Misalign,
  output logic [XLEN-1:0] Bad_Addr
);

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_cnt_q;
  logic [XLEN-1:0] next_pc;
  logic            retire;

  assign retire = (state_q == EXEC) && !Stall;

`ifdef PC_MISALIGN_TRAP_EN
  logic            misaligned;
  logic            misalign_q;
  logic [XLEN-1:0] bad_addr_q;

  pc_next_sel u_next_sel (
    .PC           (pc_q),
    .PC_Target    (PC_Target),
    .Branch_Taken (Branch_Taken),
    .Trap_Vector  (TRAP_VECTOR),
    .Misaligned   (misaligned),
    .Next_PC      (next_pc)
  );
`else
  pc_next_sel u_next_sel (
    .PC           (pc_q),
    .PC_Target    (PC_Target),
    .Branch_Taken (Branch_Taken),
    .Next_PC      (next_pc)
  );
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ:  if (Fetch_Ack) state_d = EXEC;
      EXEC: if (!Stall) state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  // handshake outputs decode from state only
  always_comb begin
    Fetch_Req   = 1'b0;
    Instr_Valid = 1'b0;
    unique case (1'b1)
      state_q == REQ:  Fetch_Req   = 1'b1;
      state_q == EXEC: Instr_Valid = 1'b1;
      default: ;
    endcase
  end

  // PC advances only when an instruction retires
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else if (retire) begin
      pc_q <= next_pc;
    end
  end

  // free-running retire counter, wraps mod 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
    end else if (retire) begin
      instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // one-cycle pulse and sticky bad target on trap
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misalign_q <= retire && misaligned;
      if (retire && misaligned) begin
        bad_addr_q <= PC_Target;
      end
    end
  end

  assign Misalign = misalign_q;
  assign Bad_Addr = bad_addr_q;
`else
  assign Misalign = 1'b0;
  assign Bad_Addr = '0;
`endif

  assign PC          = pc_q;
  assign PC_Plus4    = pc_q + INSTR_STRIDE;
  assign Instr_Count = instr_cnt_q;

endmodule
